// File: rtl/button_conditioner_pkg.sv
// button_conditioner_pkg: FSM state encoding and counter-width helper for the button conditioner.
package button_conditioner_pkg;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    DEB_PRESS   = 3'd1,
    PRESSED     = 3'd2,
    LONG_HELD   = 3'd3,
    DEB_RELEASE = 3'd4
  } state_t;

  // Bits needed to hold 0..v-1, never less than one bit.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchroniser for an asynchronous single-bit input.
//   clk : destination clock
//   rst : asynchronous active-low reset, both flops clear to 0
//   d   : asynchronous input
//   q   : d delayed by two clk flops
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst)
    if (!rst) {q, meta} <= 2'b00;
    else {q, meta} <= {meta, d};

endmodule

// File: rtl/button_conditioner.sv
// button_conditioner: synchronise, debounce and classify a push-button into level, strobes and a direction bit.
//   clk           : system clock
//   rst           : asynchronous active-low reset
//   btn_raw       : raw asynchronous button, active-high
//   btn_level     : debounced button level
//   press_pulse   : one-cycle strobe on an accepted press
//   release_pulse : one-cycle strobe on an accepted release
//   long_pulse    : one-cycle strobe when a hold reaches LONG_PRESS_CYCLES
//   up_down       : direction bit, toggled by each completed short press
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES   = 1000000,
  parameter int LONG_PRESS_CYCLES = 100000000,
  parameter bit UP_DOWN_INIT      = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse,
  output logic up_down
);

  localparam int DW = clog2(DEBOUNCE_CYCLES);
  localparam int HW = clog2(LONG_PRESS_CYCLES);
  // The entry cycle counts as the first stable sample, so terminal count is N-2.
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 2);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_PRESS_CYCLES - 1);

  logic s;
  state_t state, state_nx;
  logic [DW-1:0] deb_cnt, deb_nx;
  logic [HW-1:0] hold_cnt, hold_nx;
  logic long_flag, flag_nx;
  logic level_nx, press_nx, release_nx, long_nx, ud_nx;

  sync_2ff u_sync (
    .clk(clk),
    .rst(rst),
    .d  (btn_raw),
    .q  (s)
  );

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state         <= IDLE;
      deb_cnt       <= '0;
      hold_cnt      <= '0;
      long_flag     <= 1'b0;
      btn_level     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
      up_down       <= UP_DOWN_INIT;
    end else begin
      state         <= state_nx;
      deb_cnt       <= deb_nx;
      hold_cnt      <= hold_nx;
      long_flag     <= flag_nx;
      btn_level     <= level_nx;
      press_pulse   <= press_nx;
      release_pulse <= release_nx;
      long_pulse    <= long_nx;
      up_down       <= ud_nx;
    end

  always_comb begin
    state_nx   = state;
    deb_nx     = deb_cnt;
    hold_nx    = hold_cnt;
    flag_nx    = long_flag;
    level_nx   = btn_level;
    press_nx   = 1'b0;
    release_nx = 1'b0;
    long_nx    = 1'b0;
    ud_nx      = up_down;
    case (state)
      IDLE:
        if (s) begin
          state_nx = DEB_PRESS;
          deb_nx   = '0;
        end
      DEB_PRESS:
        if (!s) state_nx = IDLE;
        else if (deb_cnt == DEB_LAST) begin
          state_nx = PRESSED;
          level_nx = 1'b1;
          press_nx = 1'b1;
          hold_nx  = '0;
        end else deb_nx = deb_cnt + 1'b1;
      // Release is tested first so a release on the terminal hold count stays a short press.
      PRESSED:
        if (!s) begin
          state_nx = DEB_RELEASE;
          deb_nx   = '0;
          flag_nx  = 1'b0;
        end else if (hold_cnt == HOLD_LAST) begin
          state_nx = LONG_HELD;
          long_nx  = 1'b1;
        end else hold_nx = hold_cnt + 1'b1;
      LONG_HELD:
        if (!s) begin
          state_nx = DEB_RELEASE;
          deb_nx   = '0;
          flag_nx  = 1'b1;
        end
      // A bounce back to 1 resumes the hold with hold_cnt untouched.
      DEB_RELEASE:
        if (s) state_nx = long_flag ? LONG_HELD : PRESSED;
        else if (deb_cnt == DEB_LAST) begin
          state_nx   = IDLE;
          level_nx   = 1'b0;
          release_nx = 1'b1;
          ud_nx      = long_flag ? up_down : ~up_down;
        end else deb_nx = deb_cnt + 1'b1;
      default: begin
        state_nx = IDLE;
        level_nx = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: directed and randomized checks of button_conditioner against a behavioural model.
module tb_button_conditioner;

  localparam int DEB  = 4;
  localparam int LONG = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_raw = 1'b0;
  logic btn_level, press_pulse, release_pulse, long_pulse, up_down;

  button_conditioner #(
    .DEBOUNCE_CYCLES  (DEB),
    .LONG_PRESS_CYCLES(LONG),
    .UP_DOWN_INIT     (1'b1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .btn_raw      (btn_raw),
    .btn_level    (btn_level),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .long_pulse   (long_pulse),
    .up_down      (up_down)
  );

  always #5 clk = ~clk;

  // Behavioural model: the debounced level flips once the synchronised input has
  // disagreed with it for DEB consecutive samples; a hold sample is any agreeing
  // sample while pressed that is not the first one after a rejected bounce.
  bit m_s1, m_s2, m_level, m_press, m_rel, m_long, m_ud, m_fired;
  int m_run, m_hold;
  int cyc = 0;

  int errors = 0;
  int checks = 0;
  int n_press = 0, n_rel = 0, n_long = 0;
  int press_at = 0, rel_at = 0, long_at = 0;
  string lit_name [64];
  logic [31:0] lit_act [64];
  logic [31:0] lit_exp [64];
  int lit_n = 0;
  int lit_done = 0;
  bit finished = 1'b0;

  function automatic void chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", n, a, e, cyc);
    end
  endfunction

  task automatic model_reset();
    {m_s1, m_s2, m_level, m_press, m_rel, m_long, m_fired} = 7'b0;
    m_ud   = 1'b1;
    m_run  = 0;
    m_hold = 0;
  endtask

  task automatic model_step();
    bit s;
    cyc++;
    if (!rst) begin
      model_reset();
      return;
    end
    s    = m_s2;
    m_s2 = m_s1;
    m_s1 = btn_raw;
    {m_press, m_rel, m_long} = 3'b000;
    if (s != m_level) begin
      m_run++;
      if (m_run == DEB) begin
        m_run   = 0;
        m_level = s;
        if (s) begin
          m_press = 1'b1;
          m_hold  = 0;
          m_fired = 1'b0;
        end else begin
          m_rel = 1'b1;
          if (!m_fired) m_ud = ~m_ud;
        end
      end
    end else if (m_run > 0) m_run = 0;
    else if (m_level && !m_fired) begin
      m_hold++;
      if (m_hold == LONG) begin
        m_long  = 1'b1;
        m_fired = 1'b1;
      end
    end
  endtask

  task automatic tick(input bit b);
    btn_raw = b;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic hold(input bit b, input int n);
    repeat (n) tick(b);
  endtask

  task automatic lit(input string n, input logic [31:0] a, input logic [31:0] e);
    lit_name[lit_n] = n;
    lit_act[lit_n]  = a;
    lit_exp[lit_n]  = e;
    lit_n++;
  endtask

  // Single compare process: every output against the model, plus queued literal checks.
  initial forever begin
    @(negedge clk);
    chk("btn_level", btn_level, m_level);
    chk("press_pulse", press_pulse, m_press);
    chk("release_pulse", release_pulse, m_rel);
    chk("long_pulse", long_pulse, m_long);
    chk("up_down", up_down, m_ud);
    if (press_pulse === 1'b1) begin n_press++; press_at = cyc; end
    if (release_pulse === 1'b1) begin n_rel++; rel_at = cyc; end
    if (long_pulse === 1'b1) begin n_long++; long_at = cyc; end
    while (lit_done < lit_n) begin
      chk(lit_name[lit_done], lit_act[lit_done], lit_exp[lit_done]);
      lit_done++;
    end
    if (finished) begin
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: summary not reached within time limit");
    $fatal(1);
  end

  initial begin
    int k, p0, r0, l0, len;
    #1 rst = 1'b0;
    model_reset();
    #1;
    lit("reset_level", btn_level, 0);
    lit("reset_up_down", up_down, 1);
    lit("reset_pulses", {press_pulse, release_pulse, long_pulse}, 0);
    hold(0, 3);
    rst = 1'b1;
    hold(0, 3);

    // Clean long press
    p0 = n_press; r0 = n_rel; l0 = n_long; k = cyc;
    hold(1, 30);
    hold(0, 12);
    lit("clean_press_n", n_press - p0, 1);
    lit("clean_press_lat", press_at - k, 6);
    lit("clean_long_n", n_long - l0, 1);
    lit("clean_long_hold", long_at - press_at, 16);
    lit("clean_rel_lat", rel_at - (k + 30), 6);
    lit("clean_rel_n", n_rel - r0, 1);
    lit("clean_up_down", up_down, 1);

    // Three short presses toggle the direction
    p0 = n_press; r0 = n_rel; l0 = n_long;
    for (int i = 0; i < 3; i++) begin
      hold(1, 10);
      hold(0, 10);
      lit("toggle_up_down", up_down, (i % 2 == 0) ? 0 : 1);
    end
    lit("toggle_press_n", n_press - p0, 3);
    lit("toggle_rel_n", n_rel - r0, 3);
    lit("toggle_long_n", n_long - l0, 0);

    // Bounce shorter than the debounce window
    p0 = n_press; r0 = n_rel; l0 = n_long;
    hold(1, 3); hold(0, 1); hold(1, 2); hold(0, 10);
    lit("bounce_pulses", (n_press - p0) + (n_rel - r0) + (n_long - l0), 0);
    lit("bounce_up_down", up_down, 0);

    // Release bounce, short overall
    p0 = n_press; r0 = n_rel; l0 = n_long;
    hold(1, 12); hold(0, 2); hold(1, 8); hold(0, 12);
    lit("relb_press_n", n_press - p0, 1);
    lit("relb_rel_n", n_rel - r0, 1);
    lit("relb_long_n", n_long - l0, 0);
    lit("relb_up_down", up_down, 1);

    // Release bounce, hold count resumes and reaches long press
    p0 = n_press; r0 = n_rel; l0 = n_long;
    hold(1, 12); hold(0, 2); hold(1, 14); hold(0, 12);
    lit("relb2_long_n", n_long - l0, 1);
    lit("relb2_long_hold", long_at - press_at, 19);
    lit("relb2_rel_n", n_rel - r0, 1);
    lit("relb2_up_down", up_down, 1);

    // Short press to move direction away from its reset value
    hold(1, 10); hold(0, 10);
    lit("pre_rst_up_down", up_down, 0);

    // Reset while pressed, button still held after release of reset
    hold(1, 10);
    #2 rst = 1'b0;
    model_reset();
    #1;
    lit("rst_level", btn_level, 0);
    lit("rst_up_down", up_down, 1);
    p0 = n_press; r0 = n_rel; l0 = n_long;
    hold(1, 3);
    lit("rst_no_pulses", (n_press - p0) + (n_rel - r0) + (n_long - l0), 0);
    rst = 1'b1;
    k = cyc;
    hold(1, 10);
    lit("rst_press_n", n_press - p0, 1);
    lit("rst_press_lat", press_at - k, 6);
    hold(0, 12);

    // Release lands on the terminal hold count: short press wins
    p0 = n_press; r0 = n_rel; l0 = n_long;
    hold(1, 19); hold(0, 12);
    lit("term_long_n", n_long - l0, 0);
    lit("term_rel_n", n_rel - r0, 1);
    lit("term_up_down", up_down, 1);

    // Randomized segments with occasional resets
    for (int i = 0; i < 300; i++) begin
      len = ($urandom_range(0, 3) == 0) ? $urandom_range(10, 40) : $urandom_range(1, 6);
      hold(i % 2 == 0, len);
      if ($urandom_range(0, 40) == 0) begin
        #2 rst = 1'b0;
        model_reset();
        hold(btn_raw, 2);
        rst = 1'b1;
      end
    end
    hold(0, 20);
    finished = 1'b1;
    forever tick(1'b0);
  end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Conditions the raw mechanical direction push-button before it reaches the up/down counter's up_down input.
- Pipeline: 2-flop synchroniser, then a debounce/long-press FSM.
- Outputs: a clean level, single-cycle press/release/long-press strobes, and a registered up_down direction bit that toggles on each completed short press.
- One instance per button, placed ahead of the counter in top.

Parameters:
- DEBOUNCE_CYCLES, default 1000000: consecutive stable cycles required to accept an edge (10 ms at 100 MHz). Must be ≥2.
- LONG_PRESS_CYCLES, default 100000000: cycles held after an accepted press before long_pulse fires (1 s). Must be ≥2.
- UP_DOWN_INIT, default 1: reset value of up_down (1 = count up).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset. rst=0 resets all state immediately; release is synchronous to clk.
- btn_raw  in  1  raw asynchronous button, active-high.
- btn_level  out  1  debounced button level.
- press_pulse  out  1  one-cycle strobe when a press is accepted.
- release_pulse  out  1  one-cycle strobe when a release is accepted.
- long_pulse  out  1  one-cycle strobe when a hold reaches LONG_PRESS_CYCLES.
- up_down  out  1  direction to the counter; toggles on release of a short press.

Behaviour:
- Reset (rst=0):
  - sync flops = 0, state = IDLE, both counters = 0, long_flag = 0.
  - btn_level = 0, all pulses = 0, up_down = UP_DOWN_INIT.
- Synchroniser: s = btn_raw delayed two clk flops. The FSM sees only s.
- All outputs are registered. Pulses are high for exactly one cycle.
- Counter widths: deb_cnt = clog2(DEBOUNCE_CYCLES); hold_cnt = clog2(LONG_PRESS_CYCLES). Neither counter may ever wrap.
- IDLE:
  - s=1 → DEB_PRESS, deb_cnt=0.
- DEB_PRESS:
  - s=0 → IDLE (bounce rejected, no outputs).
  - s=1 and deb_cnt==DEBOUNCE_CYCLES-2 → PRESSED. Next cycle: btn_level=1, press_pulse=1, hold_cnt=0.
  - Otherwise deb_cnt++.
  - Net effect: press_pulse is high in the cycle after s has been 1 for DEBOUNCE_CYCLES consecutive cycles.
- PRESSED:
  - s=0 → DEB_RELEASE, deb_cnt=0, long_flag=0.
  - hold_cnt==LONG_PRESS_CYCLES-1 → LONG_HELD, long_pulse=1.
  - Otherwise hold_cnt++.
- LONG_HELD:
  - hold_cnt frozen; long_pulse fires once per press only.
  - s=0 → DEB_RELEASE, deb_cnt=0, long_flag=1.
- DEB_RELEASE:
  - btn_level stays 1.
  - s=1 → return to PRESSED if long_flag=0, else LONG_HELD. hold_cnt is preserved, no pulses.
  - s=0 and deb_cnt==DEBOUNCE_CYCLES-2 → IDLE. Next cycle: btn_level=0, release_pulse=1, and up_down toggles only if long_flag=0.
  - Otherwise deb_cnt++.
- Simultaneous events: the release transition out of PRESSED takes priority over the long-press terminal count in the same cycle, so no long_pulse and the press counts as short.
- Reset mid-press: all state clears immediately and no pulses are emitted. A button still held after rst deasserts must go through a full DEB_PRESS.
- up_down is changed only by a short-press release or by reset.
- Illegal state encodings → IDLE.

Decomposition:
- Package button_conditioner_pkg holds:
  - state encoding localparams IDLE, DEB_PRESS, PRESSED, LONG_HELD, DEB_RELEASE (3-bit);
  - a clog2 function for counter widths.
- Sub-module sync_2ff: two-flop synchroniser with async active-low rst, reset value 0. Reusable for the rst/up_down switch inputs elsewhere in top.
- FSM, counters and output registers live in button_conditioner.

Test Plan (DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=16, UP_DOWN_INIT=1):
- Clean press: btn_raw 0→1 held 30 cycles, then 0 → press_pulse exactly once, 6 cycles after the edge (2 sync + 4 debounce). No long_pulse yet at 15 hold cycles; long_pulse once at hold 16. After release, release_pulse 6 cycles after the falling edge; up_down stays 1 (long press).
- Short press toggle: three presses of 10 cycles each, gaps of 10 → up_down sequence 1→0→1→0. Three press_pulses, three release_pulses, no long_pulse.
- Bounce rejection: btn_raw high for 3 cycles, low 1, high 2, low → no pulses, btn_level stays 0, up_down unchanged.
- Release bounce: accepted press, then btn_raw low 2 cycles, high again for 8, then low → single release_pulse at the final release; up_down toggles once; hold_cnt continues from its preserved value.
- Reset mid-hold: rst=0 asynchronously during PRESSED → btn_level=0 and up_down=1 within the same cycle, no pulses. rst=1 with btn_raw still high → press_pulse again 6 cycles after rst release.
- Release on terminal count: release timed so s falls in the cycle hold_cnt==15 → no long_pulse, and up_down toggles on release.
